// File: rtl/el2_lsu_trigger_hit_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : el2_lsu_trigger_hit_ctl_if
//  Description : Signal bundle between the LSU trigger match logic, the
//                trigger hit controller and dec_tlu.
//                  LSU side   : lsu_trigger_match_m, lsu_valid_m,
//                               lsu_flush_m, lsu_flush_r, dbg_mode
//                  CSR side   : trig_chain, trig_action, trig_hit_clr
//                  dec_tlu    : dec_tlu_trig_ack (in), lsu_trig_req,
//                               lsu_trig_halt, lsu_trig_hit_vec (out)
//                  status     : lsu_trig_hit_sticky, lsu_trig_drop_cnt
//                modport slave  : the hit controller
//                modport master : whatever drives the controller
//  Revision    : 1.0  initial release
// ============================================================================
interface el2_lsu_trigger_hit_ctl_if;
    logic [3:0] lsu_trigger_match_m;
    logic       lsu_valid_m;
    logic       lsu_flush_m;
    logic       lsu_flush_r;
    logic       dbg_mode;
    logic [1:0] trig_chain;
    logic [3:0] trig_action;
    logic [3:0] trig_hit_clr;
    logic       dec_tlu_trig_ack;
    logic       lsu_trig_req;
    logic       lsu_trig_halt;
    logic [3:0] lsu_trig_hit_vec;
    logic [3:0] lsu_trig_hit_sticky;
    logic [3:0] lsu_trig_drop_cnt;

    modport slave (
        input  lsu_trigger_match_m, lsu_valid_m, lsu_flush_m, lsu_flush_r,
               dbg_mode, trig_chain, trig_action, trig_hit_clr,
               dec_tlu_trig_ack,
        output lsu_trig_req, lsu_trig_halt, lsu_trig_hit_vec,
               lsu_trig_hit_sticky, lsu_trig_drop_cnt
    );

    modport master (
        output lsu_trigger_match_m, lsu_valid_m, lsu_flush_m, lsu_flush_r,
               dbg_mode, trig_chain, trig_action, trig_hit_clr,
               dec_tlu_trig_ack,
        input  lsu_trig_req, lsu_trig_halt, lsu_trig_hit_vec,
               lsu_trig_hit_sticky, lsu_trig_drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/el2_lsu_trigger_hit_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : el2_lsu_trigger_hit_ctl
//  Description : Registers the M-stage trigger match vector into R, qualifies
//                it against flushes and debug mode, applies mcontrol chaining
//                (pairs 0/1 and 2/3) and holds a single breakpoint/halt
//                request toward dec_tlu until acknowledged. Also keeps sticky
//                per-trigger hit bits and a saturating count of qualified
//                hits that arrived while a request was already outstanding.
//  Ports       : clk    - core clock
//                rst_l  - synchronous active-low reset
//                bus    - el2_lsu_trigger_hit_ctl_if.slave (all data/handshake)
//  Revision    : 1.0  initial release
// ============================================================================
module el2_lsu_trigger_hit_ctl (
    input  wire logic                        clk,
    input  wire logic                        rst_l,
    el2_lsu_trigger_hit_ctl_if.slave         bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [3:0] C_DROP_MAX = 4'd15;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_capture;
    logic       w_ack_pend;

    logic [3:0] r_match;
    logic [3:0] w_qual;
    logic [3:0] w_hit;
    logic       w_any_hit;
    logic       w_pair01_ok;
    logic       w_pair23_ok;

    logic       r_halt;
    logic [3:0] r_hit_vec;
    logic [3:0] r_sticky;
    logic [3:0] r_drop_cnt;
    logic [3:0] w_sticky_next;
    logic [3:0] w_drop_next;

    // ------------------------------------------------------------------
    // Qualification and chaining of the R-stage match vector
    // ------------------------------------------------------------------
    assign w_qual      = r_match & {4{~bus.lsu_flush_r & ~bus.dbg_mode}};
    assign w_pair01_ok = w_qual[0] & w_qual[1];
    assign w_pair23_ok = w_qual[2] & w_qual[3];

    // A chained pair fires only as a whole: both bits survive or neither does.
    assign w_hit[1:0]  = bus.trig_chain[0] ? {2{w_pair01_ok}} : w_qual[1:0];
    assign w_hit[3:2]  = bus.trig_chain[1] ? {2{w_pair23_ok}} : w_qual[3:2];
    assign w_any_hit   = |w_hit;

    // ------------------------------------------------------------------
    // Request state machine: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_ack_pend   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // An ack seen here has nothing to acknowledge and is ignored.
                if (w_any_hit) begin
                    w_state_next = PEND;
                    w_capture    = 1'b1;
                end
            end
            PEND: begin
                // Only ack (or reset) leaves PEND; dbg_mode changes do not.
                if (bus.dec_tlu_trig_ack) begin
                    w_state_next = IDLE;
                    w_ack_pend   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Set wins over clear when both hit the same bit in one cycle.
    assign w_sticky_next = (r_sticky & ~bus.trig_hit_clr) | (w_capture ? w_hit : 4'd0);

    // Hits arriving while a request is outstanding (including the ack cycle)
    // are dropped and counted; a hit-free ack restarts the count.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (r_state == PEND) begin
            if (w_any_hit) begin
                if (r_drop_cnt != C_DROP_MAX) begin
                    w_drop_next = r_drop_cnt + 4'd1;
                end
            end else if (bus.dec_tlu_trig_ack) begin
                w_drop_next = 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state    <= IDLE;
            r_match    <= 4'd0;
            r_halt     <= 1'b0;
            r_hit_vec  <= 4'd0;
            r_sticky   <= 4'd0;
            r_drop_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_match    <= bus.lsu_trigger_match_m
                          & {4{bus.lsu_valid_m & ~bus.lsu_flush_m}};
            r_sticky   <= w_sticky_next;
            r_drop_cnt <= w_drop_next;
            if (w_capture) begin
                r_hit_vec <= w_hit;
                // Any halt-action trigger in the set promotes the whole
                // request to a debug halt.
                r_halt    <= |(w_hit & bus.trig_action);
            end else if (w_ack_pend) begin
                r_hit_vec <= 4'd0;
                r_halt    <= 1'b0;
            end
        end
    end

    assign bus.lsu_trig_req        = (r_state == PEND);
    assign bus.lsu_trig_halt       = r_halt;
    assign bus.lsu_trig_hit_vec    = r_hit_vec;
    assign bus.lsu_trig_hit_sticky = r_sticky;
    assign bus.lsu_trig_drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_el2_lsu_trigger_hit_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_el2_lsu_trigger_hit_ctl
//  Description : Self-checking bench for el2_lsu_trigger_hit_ctl. A table of
//                single-transaction vectors is applied through a scoreboard
//                queue, followed by hand-written multi-cycle sequences
//                (drop counter saturation, ack-with-hit, sticky set/clear,
//                reset during a pending request).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_el2_lsu_trigger_hit_ctl;

    logic clk;
    logic rst_l;

    el2_lsu_trigger_hit_ctl_if bus();

    el2_lsu_trigger_hit_ctl dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] match;
        logic       valid;
        logic       flush_m;
        logic       flush_r;
        logic       dbg;
        logic [1:0] chain;
        logic [3:0] action;
        logic       req;
        logic       halt;
        logic [3:0] hit;
    } vec_t;

    typedef struct packed {
        logic       req;
        logic       halt;
        logic [3:0] hit;
    } exp_t;

    localparam int C_NVEC = 11;

    vec_t vecs [C_NVEC];
    exp_t sb_q [$];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.lsu_trigger_match_m = 4'd0;
        bus.lsu_valid_m         = 1'b0;
        bus.lsu_flush_m         = 1'b0;
        bus.lsu_flush_r         = 1'b0;
        bus.dbg_mode            = 1'b0;
        bus.trig_chain          = 2'b00;
        bus.trig_action         = 4'd0;
        bus.trig_hit_clr        = 4'd0;
        bus.dec_tlu_trig_ack    = 1'b0;
    endtask

    // Two idle cycles with all sticky bits being cleared, so each vector
    // starts from IDLE, empty R stage and zero sticky status.
    task automatic clean_start();
        idle_inputs();
        bus.trig_hit_clr = 4'hF;
        tick();
        tick();
        bus.trig_hit_clr = 4'd0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        clean_start();
        bus.lsu_trigger_match_m = v.match;
        bus.lsu_valid_m         = v.valid;
        bus.lsu_flush_m         = v.flush_m;
        bus.dbg_mode            = v.dbg;
        bus.trig_chain          = v.chain;
        bus.trig_action         = v.action;
        sb_q.push_back('{req: v.req, halt: v.halt, hit: v.hit});
        tick();
        bus.lsu_trigger_match_m = 4'd0;
        bus.lsu_valid_m         = 1'b0;
        bus.lsu_flush_m         = 1'b0;
        bus.lsu_flush_r         = v.flush_r;
        tick();
        bus.lsu_flush_r = 1'b0;
        bus.dbg_mode    = 1'b0;
        e = sb_q.pop_front();
        chk($sformatf("vec%0d_req", idx),    {7'd0, bus.lsu_trig_req},     {7'd0, e.req});
        chk($sformatf("vec%0d_halt", idx),   {7'd0, bus.lsu_trig_halt},    {7'd0, e.halt});
        chk($sformatf("vec%0d_hit", idx),    {4'd0, bus.lsu_trig_hit_vec}, {4'd0, e.hit});
        chk($sformatf("vec%0d_sticky", idx), {4'd0, bus.lsu_trig_hit_sticky}, {4'd0, e.hit});
        if (e.req) begin
            bus.dec_tlu_trig_ack = 1'b1;
            tick();
            bus.dec_tlu_trig_ack = 1'b0;
            chk($sformatf("vec%0d_ack_req", idx),  {7'd0, bus.lsu_trig_req},     8'd0);
            chk($sformatf("vec%0d_ack_hit", idx),  {4'd0, bus.lsu_trig_hit_vec}, 8'd0);
            chk($sformatf("vec%0d_ack_drop", idx), {4'd0, bus.lsu_trig_drop_cnt}, 8'd0);
        end
    endtask

    initial begin
        //            match    v     fm    fr    dbg   chain  action   req   halt  hit
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 4'b0100};
        vecs[1]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0011};
        vecs[3]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b0, 4'b0011};
        vecs[4]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b1, 1'b1, 4'b1001};
        vecs[5]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[6]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[9]  = '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0100, 1'b1, 1'b1, 4'b1100};
        vecs[10] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0010, 1'b1, 1'b0, 4'b0100};

        // Reset state
        idle_inputs();
        rst_l = 1'b0;
        tick();
        tick();
        chk("rst_req",    {7'd0, bus.lsu_trig_req},        8'd0);
        chk("rst_halt",   {7'd0, bus.lsu_trig_halt},       8'd0);
        chk("rst_hit",    {4'd0, bus.lsu_trig_hit_vec},    8'd0);
        chk("rst_sticky", {4'd0, bus.lsu_trig_hit_sticky}, 8'd0);
        chk("rst_drop",   {4'd0, bus.lsu_trig_drop_cnt},   8'd0);
        rst_l = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < C_NVEC; i++) begin
            apply_vec(vecs[i], i);
        end

        // Drop counter saturation, then hit-free ack clears it
        clean_start();
        bus.lsu_trigger_match_m = 4'b0001;
        bus.lsu_valid_m         = 1'b1;
        tick();
        tick();
        chk("sat_req0",  {7'd0, bus.lsu_trig_req},      8'd1);
        chk("sat_drop0", {4'd0, bus.lsu_trig_drop_cnt}, 8'd0);
        tick();
        chk("sat_drop1", {4'd0, bus.lsu_trig_drop_cnt}, 8'd1);
        repeat (19) tick();
        chk("sat_drop15", {4'd0, bus.lsu_trig_drop_cnt}, 8'd15);
        chk("sat_req",    {7'd0, bus.lsu_trig_req},      8'd1);
        chk("sat_hit",    {4'd0, bus.lsu_trig_hit_vec},  8'h01);
        bus.lsu_valid_m         = 1'b0;
        bus.lsu_trigger_match_m = 4'd0;
        tick();
        chk("sat_hold15", {4'd0, bus.lsu_trig_drop_cnt}, 8'd15);
        bus.dec_tlu_trig_ack = 1'b1;
        tick();
        bus.dec_tlu_trig_ack = 1'b0;
        chk("sat_ack_req",  {7'd0, bus.lsu_trig_req},      8'd0);
        chk("sat_ack_drop", {4'd0, bus.lsu_trig_drop_cnt}, 8'd0);

        // Ack in a cycle with a hit: the hit is dropped and counted,
        // the next hit in IDLE is captured again
        clean_start();
        bus.lsu_trigger_match_m = 4'b0010;
        bus.lsu_valid_m         = 1'b1;
        tick();
        tick();
        chk("ackhit_req0", {7'd0, bus.lsu_trig_req}, 8'd1);
        bus.dec_tlu_trig_ack = 1'b1;
        tick();
        bus.dec_tlu_trig_ack = 1'b0;
        chk("ackhit_req",  {7'd0, bus.lsu_trig_req},      8'd0);
        chk("ackhit_drop", {4'd0, bus.lsu_trig_drop_cnt}, 8'd1);
        tick();
        chk("ackhit_recap_req", {7'd0, bus.lsu_trig_req},     8'd1);
        chk("ackhit_recap_hit", {4'd0, bus.lsu_trig_hit_vec}, 8'h02);
        bus.lsu_valid_m = 1'b0;
        tick();
        chk("ackhit_drop2", {4'd0, bus.lsu_trig_drop_cnt}, 8'd2);
        bus.dec_tlu_trig_ack = 1'b1;
        tick();
        bus.dec_tlu_trig_ack = 1'b0;
        chk("ackhit_end_drop", {4'd0, bus.lsu_trig_drop_cnt}, 8'd0);

        // Sticky: set wins over a same-cycle clear, a later clear removes it
        clean_start();
        bus.lsu_trigger_match_m = 4'b0100;
        bus.lsu_valid_m         = 1'b1;
        tick();
        bus.lsu_valid_m  = 1'b0;
        bus.trig_hit_clr = 4'b0100;
        tick();
        bus.trig_hit_clr = 4'd0;
        chk("sticky_setwins", {4'd0, bus.lsu_trig_hit_sticky}, 8'h04);
        bus.dec_tlu_trig_ack = 1'b1;
        tick();
        bus.dec_tlu_trig_ack = 1'b0;
        chk("sticky_after_ack", {4'd0, bus.lsu_trig_hit_sticky}, 8'h04);
        bus.trig_hit_clr = 4'b0100;
        tick();
        bus.trig_hit_clr = 4'd0;
        chk("sticky_clr", {4'd0, bus.lsu_trig_hit_sticky}, 8'h00);

        // Ack while IDLE is ignored
        bus.dec_tlu_trig_ack = 1'b1;
        tick();
        bus.dec_tlu_trig_ack = 1'b0;
        chk("idle_ack_req",  {7'd0, bus.lsu_trig_req},      8'd0);
        chk("idle_ack_drop", {4'd0, bus.lsu_trig_drop_cnt}, 8'd0);

        // dbg_mode in PEND keeps the request but masks new hits; then reset
        clean_start();
        bus.lsu_trigger_match_m = 4'b1000;
        bus.lsu_valid_m         = 1'b1;
        bus.trig_action         = 4'b1000;
        tick();
        tick();
        chk("pend_halt", {7'd0, bus.lsu_trig_halt},    8'd1);
        chk("pend_hit",  {4'd0, bus.lsu_trig_hit_vec}, 8'h08);
        bus.dbg_mode = 1'b1;
        tick();
        chk("dbg_keep_req", {7'd0, bus.lsu_trig_req},      8'd1);
        chk("dbg_no_drop",  {4'd0, bus.lsu_trig_drop_cnt}, 8'd0);
        bus.dbg_mode = 1'b0;
        tick();
        chk("pend_drop1", {4'd0, bus.lsu_trig_drop_cnt}, 8'd1);
        rst_l = 1'b0;
        tick();
        chk("mid_rst_req",    {7'd0, bus.lsu_trig_req},        8'd0);
        chk("mid_rst_halt",   {7'd0, bus.lsu_trig_halt},       8'd0);
        chk("mid_rst_hit",    {4'd0, bus.lsu_trig_hit_vec},    8'd0);
        chk("mid_rst_sticky", {4'd0, bus.lsu_trig_hit_sticky}, 8'd0);
        chk("mid_rst_drop",   {4'd0, bus.lsu_trig_drop_cnt},   8'd0);
        // M-stage match present during reset must not survive it
        rst_l = 1'b1;
        bus.lsu_valid_m         = 1'b0;
        bus.lsu_trigger_match_m = 4'd0;
        tick();
        tick();
        chk("post_rst_req", {7'd0, bus.lsu_trig_req}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
